// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: single-cycle logic/arith ops, iterative shifts and shift-add multiply
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             overflow,
    output logic             carry
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_op;
    logic [SHW:0]         r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_res;
    logic                 r_ovf;
    logic                 r_cy;
    logic                 r_valid;

    logic                 w_accept;
    logic                 w_is_shift;
    logic                 w_multi;
    logic [SHW-1:0]       w_s;
    logic [WIDTH:0]       w_add;
    logic [WIDTH-1:0]     w_sub;
    logic [WIDTH-1:0]     w_sc_res;
    logic                 w_sc_ovf;
    logic                 w_sc_cy;
    logic [2*WIDTH-1:0]   w_acc_nx;
    logic [WIDTH:0]       w_psum;
    logic                 w_out_bit;
    logic                 w_last;

    assign w_s        = A[SHW-1:0];
    assign w_accept   = start && (r_state != S_RUN);
    assign w_is_shift = (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
    assign w_multi    = (w_is_shift && (w_s != '0)) || (op == OP_MULU);
    assign w_add      = {1'b0, A} + {1'b0, B};
    assign w_sub      = A - B;
    assign w_last     = (r_cnt == (SHW+1)'(1));

    // Shifts with s=0 fall through here and simply pass B.
    always_comb begin
        w_sc_res = '0;
        w_sc_ovf = 1'b0;
        w_sc_cy  = 1'b0;
        case (op)
            OP_AND:  w_sc_res = A & B;
            OP_OR:   w_sc_res = A | B;
            OP_XOR:  w_sc_res = A ^ B;
            OP_NOR:  w_sc_res = ~(A | B);
            OP_ADD: begin
                w_sc_res = w_add[WIDTH-1:0];
                w_sc_cy  = w_add[WIDTH];
                w_sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_res = w_sub;
                w_sc_cy  = (A < B);
                w_sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SRL, OP_SLL, OP_SRA: w_sc_res = B;
            default: w_sc_res = '0;
        endcase
    end

    // One iteration step: a single-bit shift, or one shift-add of the multiplier.
    always_comb begin
        w_acc_nx  = r_acc;
        w_out_bit = 1'b0;
        w_psum    = '0;
        case (r_op)
            OP_SRL: begin
                w_acc_nx  = {{WIDTH{1'b0}}, 1'b0, r_acc[WIDTH-1:1]};
                w_out_bit = r_acc[0];
            end
            OP_SRA: begin
                w_acc_nx  = {{WIDTH{1'b0}}, r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
                w_out_bit = r_acc[0];
            end
            OP_SLL: begin
                w_acc_nx  = {{WIDTH{1'b0}}, r_acc[WIDTH-2:0], 1'b0};
                w_out_bit = r_acc[WIDTH-1];
            end
            OP_MULU: begin
                w_psum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
                w_acc_nx = {w_psum, r_acc[WIDTH-1:1]};
            end
            default: w_acc_nx = r_acc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_multi ? S_RUN : S_DONE;
            S_RUN:  if (w_last)   w_next = S_DONE;
            S_DONE: begin
                if (w_accept) w_next = w_multi ? S_RUN : S_DONE;
                else          w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_res   <= '0;
            r_ovf   <= 1'b0;
            r_cy    <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_op    <= op;
            r_mcand <= A;
            r_acc   <= {{WIDTH{1'b0}}, B};
            if (w_multi) begin
                r_cnt <= (op == OP_MULU) ? (SHW+1)'(WIDTH) : {1'b0, w_s};
            end else begin
                r_cnt   <= '0;
                r_res   <= w_sc_res;
                r_ovf   <= w_sc_ovf;
                r_cy    <= w_sc_cy;
                r_valid <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nx;
            r_cnt <= r_cnt - (SHW+1)'(1);
            if (w_last) begin
                r_res   <= w_acc_nx[WIDTH-1:0];
                r_ovf   <= 1'b0;
                r_cy    <= (r_op == OP_MULU) ? (|w_acc_nx[2*WIDTH-1:WIDTH]) : w_out_bit;
                r_valid <= 1'b1;
            end
        end
    end

    // r_valid keeps zero low after reset until a result has actually been produced.
    assign res      = r_res;
    assign overflow = r_ovf;
    assign carry    = r_cy;
    assign zero     = r_valid && (r_res == '0);

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, the successor to the single-cycle 8-op ALU in the MDP datapath. It keeps the original 3-bit opcode map in the low eight codes. It adds full-width iterative shifts (SRL/SLL/SRA by any amount), SLTU and an iterative unsigned multiply, all behind a start/done handshake. The block sits beside the register file; the control FSM stalls on `busy` and takes results on `done`.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width; derived, not overridden.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; accepted only on an edge where `busy`=0.
- `op` in 4: operation, sampled with `start`.
- `A` in WIDTH: operand A; for shifts only `A[SHW-1:0]` is used as the shift amount s.
- `B` in WIDTH: operand B; value shifted for shifts.
- `busy` out 1: operation in progress; `start` is ignored.
- `done` out 1: one-cycle pulse; `res` and flags are valid from this cycle until the next accept.
- `res` out WIDTH: result.
- `zero` out 1: `res`==0.
- `overflow` out 1: signed overflow.
- `carry` out 1: carry/borrow/shift-out/product-high flag.

## Operation
- Opcodes:
  - 0000 AND A&B
  - 0001 OR A|B
  - 0010 ADD A+B
  - 0011 XOR A^B
  - 0100 NOR ~(A|B)
  - 0101 SRL B>>s
  - 0110 SUB A−B
  - 0111 SLT signed A<B ? 1 : 0
  - 1000 SLL B<<s
  - 1001 SRA B>>>s, arithmetic
  - 1010 SLTU unsigned A<B
  - 1011 MULU low WIDTH bits of A×B, unsigned
  - 1100–1111 reserved: `res`=0, all flags 0, single-cycle.
- States and transitions:
  - IDLE → DONE on accept of a single-cycle op, or of a shift with s=0.
  - IDLE → RUN on accept of a shift with s>0, or of MULU.
  - RUN → DONE on the last iteration edge.
  - DONE → IDLE if no `start` that cycle.
  - DONE → DONE or RUN if a new `start` is accepted (back-to-back).
- Accept edge: A, B, op and s are latched into working registers. Single-cycle results are computed and registered on this same edge.
- Shifts:
  - One bit per RUN edge; a down-counter is loaded with s.
  - DONE follows the edge on which the counter reaches 0.
- MULU:
  - Radix-2 shift-add over WIDTH RUN edges.
  - Internal 2·WIDTH accumulator.
  - `res` = low half.
- Flags are registered with `res`; `zero` is always derived from the registered `res`.
  - `overflow`:
    - ADD: operand signs equal and result sign differs.
    - SUB: operand signs differ and result sign differs from A.
    - All other ops: 0.
  - `carry`:
    - ADD: carry-out of bit WIDTH−1.
    - SUB: borrow, i.e. unsigned A<B.
    - Shifts: last bit shifted out (0 when s=0).
    - MULU: 1 if the high half of the product ≠ 0.
    - All other ops: 0.
- `start` while `busy`=1 is ignored, with no side effects. Operand changes during RUN have no effect.
- `rst` asserted at any time, including mid-RUN:
  - state goes to IDLE and the counter clears;
  - `busy`, `done`, `res`, `zero`, `overflow` and `carry` all go to 0.
  - The `zero` output is also forced to 0 under reset; it is not computed from `res`.

## Timing
- Latency L runs from the accept edge to the edge that raises `done`:
  - 1 for logic, arithmetic, compare and reserved ops;
  - 1+s for shifts;
  - 1+WIDTH for MULU.
- `busy`=1 exactly during RUN, i.e. L−1 cycles; it is 0 in IDLE and DONE.
- `done`=1 for exactly one cycle per accepted op.
- Back-to-back: `start` in the DONE cycle is accepted. Sustained throughput is one single-cycle op per clock.
- `res` and flags hold their value after `done` until the next accept edge updates them.
- Reset values: all outputs 0; state IDLE.

## Test plan
- Reset, then ADD with A=0x7FFFFFFF, B=1 → `done` one cycle later; `res`=0x80000000, `overflow`=1, `carry`=0, `zero`=0.
- SUB with A=5, B=5 → `res`=0, `zero`=1, `carry`=0. Then SUB with A=3, B=5 → `res`=0xFFFFFFFE, `carry`=1. Issue both back-to-back, with the second `start` in the DONE cycle: two consecutive `done` pulses.
- SRA with A=4, B=0xF0000010 → `busy` high 4 cycles, `done` at L=5, `res`=0xFF000001, `carry`=0. SRL with A=0x20 (s=0), B=0x12345678 → L=1, `res`=0x12345678, `carry`=0.
- MULU with A=0x10000, B=0x10001 → L=33, `res`=0x00010000, `carry`=1. Pulse `start` with ADD mid-RUN → ignored, result unchanged.
- SLT with A=0xFFFFFFFF, B=1 → `res`=1. SLTU with the same operands → `res`=0. Reserved op 1110 → `res`=0, `zero`=1, `done` at L=1.
- Assert `rst` on the 10th RUN cycle of MULU → all outputs 0 immediately (async). After release, an AND with A=0xF0F0, B=0xFF00 → `res`=0xF000.
